// File: rtl/guess_judge_fsm.sv
// Up/down number-game judge: samples comparator flags on each guess strobe,
// issues HIGH/LOW hints, narrows the legal secret range and declares WIN/LOSE.
module guess_judge_fsm #(
  parameter int W       = 4,
  parameter int MAX_TRY = 7
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iStart,
  input  logic         iValid,
  input  logic [W-1:0] iGuess,
  input  logic         iAgtB,
  input  logic         iAltB,
  input  logic         iAeqB,
  output logic         oHigh,
  output logic         oLow,
  output logic         oWin,
  output logic         oLose,
  output logic         oBusy,
  output logic         oErr,
  output logic [3:0]   oTryCnt,
  output logic [W-1:0] oLoBnd,
  output logic [W-1:0] oHiBnd
);

  typedef enum logic [1:0] {
    Idle,
    Play,
    Win,
    Lose
  } stateT;

  localparam logic [W-1:0] AllOnes = '1;
  localparam logic [W-1:0] One     = W'(1);
  localparam logic [3:0]   MaxTry  = 4'(MAX_TRY);

  stateT        state, stateNext;
  logic         highNext, lowNext, errNext;
  logic [3:0]   tryNext, tryInc;
  logic [W-1:0] loNext, hiNext;
  logic         flagsOneHot, guessIllegal;

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state   <= Idle;
      oHigh   <= 1'b0;
      oLow    <= 1'b0;
      oErr    <= 1'b0;
      oTryCnt <= 4'd0;
      oLoBnd  <= '0;
      oHiBnd  <= AllOnes;
    end else begin
      state   <= stateNext;
      oHigh   <= highNext;
      oLow    <= lowNext;
      oErr    <= errNext;
      oTryCnt <= tryNext;
      oLoBnd  <= loNext;
      oHiBnd  <= hiNext;
    end
  end

  // A guess that would push a bound past 0 or all-ones is rejected like an out-of-range one.
  always_comb begin
    stateNext    = state;
    highNext     = oHigh;
    lowNext      = oLow;
    errNext      = 1'b0;
    tryNext      = oTryCnt;
    loNext       = oLoBnd;
    hiNext       = oHiBnd;
    tryInc       = oTryCnt + 4'd1;
    flagsOneHot  = ({iAgtB, iAltB, iAeqB} == 3'b100) ||
                   ({iAgtB, iAltB, iAeqB} == 3'b010) ||
                   ({iAgtB, iAltB, iAeqB} == 3'b001);
    guessIllegal = !flagsOneHot || (iGuess < oLoBnd) || (iGuess > oHiBnd) ||
                   (iAgtB && (iGuess == '0)) || (iAltB && (iGuess == AllOnes));

    if (iStart) begin
      stateNext = Play;
      highNext  = 1'b0;
      lowNext   = 1'b0;
      tryNext   = 4'd0;
      loNext    = '0;
      hiNext    = AllOnes;
    end else if (iValid && (state == Play)) begin
      if (guessIllegal) begin
        errNext = 1'b1;
      end else if (iAeqB) begin
        stateNext = Win;
        highNext  = 1'b0;
        lowNext   = 1'b0;
        loNext    = iGuess;
        hiNext    = iGuess;
      end else begin
        if (iAgtB) begin
          highNext = 1'b1;
          lowNext  = 1'b0;
          hiNext   = iGuess - One;
        end else begin
          highNext = 1'b0;
          lowNext  = 1'b1;
          loNext   = iGuess + One;
        end
        tryNext = tryInc;
        if (tryInc == MaxTry) begin
          stateNext = Lose;
        end
      end
    end
  end

  assign oBusy = (state == Play);
  assign oWin  = (state == Win);
  assign oLose = (state == Lose);

endmodule

// File: tb/tb_guess_judge_fsm.sv
// Self-checking bench for guess_judge_fsm: directed game scenarios followed by
// randomized games, all checked against a rule-level reference model.
module tb_guess_judge_fsm;

  localparam int MaxTry = 7;

  logic       iClk = 1'b0;
  logic       iRsn, iStart, iValid, iAgtB, iAltB, iAeqB;
  logic [3:0] iGuess;
  logic       oHigh, oLow, oWin, oLose, oBusy, oErr;
  logic [3:0] oTryCnt, oLoBnd, oHiBnd;

  int errors = 0;
  int checks = 0;

  // Reference model of the game, kept as plain game facts rather than states.
  bit mPlaying, mWon, mLost, mHigh, mLow, mErr;
  int mTries, mLo, mHi;

  guess_judge_fsm #(.W(4), .MAX_TRY(MaxTry)) dut (
    .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iValid(iValid), .iGuess(iGuess),
    .iAgtB(iAgtB), .iAltB(iAltB), .iAeqB(iAeqB),
    .oHigh(oHigh), .oLow(oLow), .oWin(oWin), .oLose(oLose), .oBusy(oBusy), .oErr(oErr),
    .oTryCnt(oTryCnt), .oLoBnd(oLoBnd), .oHiBnd(oHiBnd)
  );

  always #5 iClk = ~iClk;

  task automatic modelStep(input bit rsn, input bit start, input bit valid,
                           input int guess, input bit gt, input bit lt, input bit eq);
    mErr = 0;
    if (!rsn) begin
      {mPlaying, mWon, mLost, mHigh, mLow} = '0;
      mTries = 0; mLo = 0; mHi = 15;
    end else if (start) begin
      mPlaying = 1; mWon = 0; mLost = 0; mHigh = 0; mLow = 0;
      mTries = 0; mLo = 0; mHi = 15;
    end else if (valid && mPlaying) begin
      if ((int'(gt) + int'(lt) + int'(eq)) != 1 || guess < mLo || guess > mHi ||
          (gt && guess == 0) || (lt && guess == 15)) begin
        mErr = 1;
      end else if (eq) begin
        mPlaying = 0; mWon = 1; mHigh = 0; mLow = 0; mLo = guess; mHi = guess;
      end else begin
        mHigh = gt; mLow = lt;
        if (gt) mHi = guess - 1;
        else    mLo = guess + 1;
        mTries++;
        if (mTries == MaxTry) begin
          mPlaying = 0; mLost = 1;
        end
      end
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, " high"}, 32'(oHigh),   32'(mHigh));
    checkValue({tag, " low"},  32'(oLow),    32'(mLow));
    checkValue({tag, " win"},  32'(oWin),    32'(mWon));
    checkValue({tag, " lose"}, 32'(oLose),   32'(mLost));
    checkValue({tag, " busy"}, 32'(oBusy),   32'(mPlaying));
    checkValue({tag, " err"},  32'(oErr),    32'(mErr));
    checkValue({tag, " try"},  32'(oTryCnt), 32'(mTries));
    checkValue({tag, " lo"},   32'(oLoBnd),  32'(mLo));
    checkValue({tag, " hi"},   32'(oHiBnd),  32'(mHi));
  endtask

  // flags are {AgtB, AltB, AeqB}; inputs change just after the falling edge.
  task automatic applyStimulus(input string tag, input bit rsn, input bit start, input bit valid,
                               input int guess, input logic [2:0] flags);
    iRsn = rsn; iStart = start; iValid = valid; iGuess = 4'(guess);
    {iAgtB, iAltB, iAeqB} = flags;
    @(posedge iClk);
    modelStep(rsn, start, valid, guess, flags[2], flags[1], flags[0]);
    @(negedge iClk);
    checkOutput(tag);
  endtask

  initial begin
    int secret, guess, r;
    logic [2:0] flags;
    {iStart, iValid, iAgtB, iAltB, iAeqB} = '0;
    iRsn = 1'b0; iGuess = 4'd0;
    @(negedge iClk);

    // Scenarios 1 and 2: hint, narrowing, win.
    applyStimulus("reset", 0, 0, 0, 0, 3'b000);
    checkValue("reset hiBnd", 32'(oHiBnd), 32'd15);
    applyStimulus("start", 1, 1, 0, 0, 3'b000);
    applyStimulus("g8 high", 1, 0, 1, 8, 3'b100);
    checkValue("g8 hiBnd", 32'(oHiBnd), 32'd7);
    checkValue("g8 try", 32'(oTryCnt), 32'd1);
    applyStimulus("g3 low", 1, 0, 1, 3, 3'b010);
    checkValue("g3 loBnd", 32'(oLoBnd), 32'd4);
    applyStimulus("g5 win", 1, 0, 1, 5, 3'b001);
    checkValue("win flag", 32'(oWin), 32'd1);
    checkValue("win try", 32'(oTryCnt), 32'd2);
    applyStimulus("win hold", 1, 0, 1, 5, 3'b100);

    // Scenario 3: seven legal wrong guesses lose the game.
    applyStimulus("restart", 1, 1, 0, 0, 3'b000);
    for (int g = 0; g < MaxTry; g++) applyStimulus("climb", 1, 0, 1, g, 3'b010);
    checkValue("lose flag", 32'(oLose), 32'd1);
    applyStimulus("lose hold", 1, 0, 1, 9, 3'b100);

    // Scenario 4: bad flags, out-of-range guess and wrap guards.
    applyStimulus("restart2", 1, 1, 0, 0, 3'b000);
    applyStimulus("flags110", 1, 0, 1, 5, 3'b110);
    checkValue("flags110 err", 32'(oErr), 32'd1);
    applyStimulus("err clears", 1, 0, 0, 0, 3'b000);
    applyStimulus("g8 again", 1, 0, 1, 8, 3'b100);
    applyStimulus("g9 range", 1, 0, 1, 9, 3'b100);
    checkValue("g9 try", 32'(oTryCnt), 32'd1);
    applyStimulus("g0 wrap", 1, 0, 1, 0, 3'b100);
    applyStimulus("restart3", 1, 1, 0, 0, 3'b000);
    applyStimulus("g15 wrap", 1, 0, 1, 15, 3'b010);

    // Scenario 5: start beats a simultaneous guess.
    applyStimulus("g4 low", 1, 0, 1, 4, 3'b010);
    applyStimulus("start+valid", 1, 1, 1, 10, 3'b100);
    checkValue("restart try", 32'(oTryCnt), 32'd0);

    // Scenario 6: reset mid-game, dominating start, then guesses ignored.
    applyStimulus("g12 high", 1, 0, 1, 12, 3'b100);
    applyStimulus("reset mid", 0, 1, 0, 0, 3'b000);
    checkValue("reset busy", 32'(oBusy), 32'd0);
    applyStimulus("idle valid", 1, 0, 1, 6, 3'b010);

    // Randomized games: mostly truthful comparator, with occasional corruption.
    for (int game = 0; game < 40; game++) begin
      secret = $urandom_range(15, 0);
      applyStimulus("rnd start", 1, 1, 0, 0, 3'b000);
      for (int step = 0; step < 14; step++) begin
        r = $urandom_range(19, 0);
        if (r == 0 || mLo > mHi) guess = $urandom_range(15, 0);
        else guess = $urandom_range(mHi, mLo);
        flags = {guess > secret, guess < secret, guess == secret};
        if (r == 1) flags = 3'($urandom_range(7, 0));
        if (r == 2) applyStimulus("rnd restart", 1, 1, 1, guess, flags);
        else if (r == 3 && step > 10) applyStimulus("rnd reset", 0, 0, 1, guess, flags);
        else applyStimulus("rnd guess", 1, 0, (r != 4), guess, flags);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
